// File: rtl/alu_seq_if.sv
// Nibble-load, ALU operand/result and result-handshake bundle for alu_sequencer.
interface alu_seq_if;
    logic [3:0]  nib;
    logic        nib_valid;
    logic        nib_ready;
    logic [11:0] a;
    logic [11:0] b;
    logic [2:0]  fun;
    logic [11:0] alu_y;
    logic [11:0] res;
    logic        res_valid;
    logic        res_ready;
    logic        zero;
    logic        neg;

    modport master (
        output nib, nib_valid, alu_y, res_ready,
        input  nib_ready, a, b, fun, res, res_valid, zero, neg
    );

    modport slave (
        input  nib, nib_valid, alu_y, res_ready,
        output nib_ready, a, b, fun, res, res_valid, zero, neg
    );
endinterface

// File: rtl/alu_sequencer.sv
// Loads A, B (three nibbles each) and a function nibble, runs one ALU cycle, holds the result.
// Optional macro ALU_SEQ_FLAGS_EN adds registered zero/neg flags alongside res.
//
// state  | meaning
// LOAD_A | collecting the three nibbles of operand A
// LOAD_B | collecting the three nibbles of operand B
// LOAD_F | waiting for the function nibble
// EXEC   | a/b/fun stable at the ALU for one cycle; result captured at the end
// HOLD   | result presented until the consumer takes it
module alu_sequencer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic reset,
    alu_seq_if.slave bus
);

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        LOAD_F = 3'd2,
        EXEC   = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [11:0] a_q, a_d;
    logic [11:0] b_q, b_d;
    logic [2:0]  fun_q, fun_d;
    logic [11:0] res_q, res_d;
    logic        res_valid_q, res_valid_d;
    logic        nib_ready_q, nib_ready_d;
    logic        nib_xfer;

    function automatic logic [11:0] load_nib(input logic [11:0] cur,
                                             input logic [1:0]  idx,
                                             input logic [3:0]  n);
        logic [11:0] r;
        r = cur;
        if (MSB_FIRST) begin
            r = {cur[7:0], n};
        end else begin
            case (idx)
                2'd0:    r[3:0]  = n;
                2'd1:    r[7:4]  = n;
                default: r[11:8] = n;
            endcase
        end
        return r;
    endfunction

    assign nib_xfer = bus.nib_valid && nib_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        fun_d       = fun_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        case (state_q)
            LOAD_A: begin
                if (nib_xfer) begin
                    a_d = load_nib(a_q, cnt_q, bus.nib);
                    if (cnt_q == 2'd2) begin
                        cnt_d   = 2'd0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            LOAD_B: begin
                if (nib_xfer) begin
                    b_d = load_nib(b_q, cnt_q, bus.nib);
                    if (cnt_q == 2'd2) begin
                        cnt_d   = 2'd0;
                        state_d = LOAD_F;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            LOAD_F: begin
                if (nib_xfer) begin
                    fun_d   = bus.nib[2:0];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d       = bus.alu_y;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
                cnt_d   = 2'd0;
            end
        endcase
        // ready is registered, so it is decoded from the state we are about to enter
        nib_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B) || (state_d == LOAD_F);
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic zero_q, zero_d;
    logic neg_q, neg_d;

    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        if (state_q == EXEC) begin
            zero_d = (bus.alu_y == 12'd0);
            neg_d  = bus.alu_y[11];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;
`else
    assign bus.zero = 1'b0;
    assign bus.neg  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD_A;
            cnt_q       <= 2'd0;
            a_q         <= 12'd0;
            b_q         <= 12'd0;
            fun_q       <= 3'd0;
            res_q       <= 12'd0;
            res_valid_q <= 1'b0;
            nib_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fun_q       <= fun_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            nib_ready_q <= nib_ready_d;
        end
    end

    assign bus.nib_ready = nib_ready_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.fun       = fun_q;
    assign bus.res       = res_q;
    assign bus.res_valid = res_valid_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: one MSB-first and one LSB-first instance with a model ALU.
module tb_alu_sequencer;

    logic clk;
    logic reset;

    alu_seq_if bus1 ();
    alu_seq_if bus0 ();

    alu_sequencer #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    alu_sequencer #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bench ALU: 2 add, 3 and, 6 subtract, anything else xor
    function automatic logic [11:0] alu_f(input logic [11:0] x, input logic [11:0] y,
                                          input logic [2:0] f);
        case (f)
            3'd2:    return x + y;
            3'd3:    return x & y;
            3'd6:    return x - y;
            default: return x ^ y;
        endcase
    endfunction

    assign bus1.alu_y = alu_f(bus1.a, bus1.b, bus1.fun);
    assign bus0.alu_y = alu_f(bus0.a, bus0.b, bus0.fun);

    int n_cmp = 0;
    int n_err = 0;
    logic [13:0] q1[$];
    logic [13:0] q0[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_flags(input logic [11:0] r);
`ifdef ALU_SEQ_FLAGS_EN
        return {r == 12'd0, r[11]};
`else
        return 2'b00;
`endif
    endfunction

    function automatic bit rdy(input bit sel);
        return sel ? bus1.nib_ready : bus0.nib_ready;
    endfunction

    // monitors: pop and compare whenever a result is handed over
    always @(negedge clk) begin
        logic [13:0] e;
        if (bus1.res_valid && bus1.res_ready) begin
            chk("sb1_pending", int'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("sb1_res", bus1.res, e[11:0]);
                chk("sb1_zero", bus1.zero, e[13]);
                chk("sb1_neg", bus1.neg, e[12]);
            end
        end
        if (bus0.res_valid && bus0.res_ready) begin
            chk("sb0_pending", int'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("sb0_res", bus0.res, e[11:0]);
                chk("sb0_zero", bus0.zero, e[13]);
                chk("sb0_neg", bus0.neg, e[12]);
            end
        end
    end

    task automatic send_nib(input bit sel, input logic [3:0] n);
        int k;
        if (sel) begin bus1.nib = n; bus1.nib_valid = 1'b1; end
        else     begin bus0.nib = n; bus0.nib_valid = 1'b1; end
        k = 0;
        @(negedge clk);
        while (!rdy(sel) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!rdy(sel)) chk("nib_ready_timeout", int'(rdy(sel)), 1);
        @(posedge clk);
        #1;
        if (sel) bus1.nib_valid = 1'b0;
        else     bus0.nib_valid = 1'b0;
    endtask

    // nibs: seven nibbles, first presented in [27:24]
    task automatic do_op(input bit sel, input logic [27:0] nibs, input logic [11:0] ea,
                         input logic [11:0] eb, input logic [2:0] ef, input logic [11:0] er);
        if (sel) q1.push_back({exp_flags(er), er});
        else     q0.push_back({exp_flags(er), er});
        for (int i = 0; i < 7; i++) send_nib(sel, nibs[27 - 4*i -: 4]);
        if (sel) begin
            chk("exec_res_valid", bus1.res_valid, 0);
            chk("exec_a", bus1.a, ea);
            chk("exec_b", bus1.b, eb);
            chk("exec_fun", bus1.fun, ef);
        end else begin
            chk("exec0_res_valid", bus0.res_valid, 0);
            chk("exec0_a", bus0.a, ea);
            chk("exec0_b", bus0.b, eb);
            chk("exec0_fun", bus0.fun, ef);
        end
        @(posedge clk);
        #1;
        chk("latency_res_valid", sel ? bus1.res_valid : bus0.res_valid, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_a", bus1.a, 0);
        chk("rst_b", bus1.b, 0);
        chk("rst_fun", bus1.fun, 0);
        chk("rst_res", bus1.res, 0);
        chk("rst_res_valid", bus1.res_valid, 0);
        chk("rst_zero", bus1.zero, 0);
        chk("rst_neg", bus1.neg, 0);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        bus1.nib = 4'h0; bus1.nib_valid = 1'b0; bus1.res_ready = 1'b1;
        bus0.nib = 4'h0; bus0.nib_valid = 1'b0; bus0.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready1", bus1.nib_ready, 1);
        chk("post_rst_ready0", bus0.nib_ready, 1);

        // MSB-first add
        do_op(1'b1, 28'h1230452, 12'h123, 12'h045, 3'd2, 12'h168);
        @(posedge clk); #1;
        chk("consumed_res_valid", bus1.res_valid, 0);
        chk("back_to_load_ready", bus1.nib_ready, 1);

        // LSB-first: 3,2,1 -> 0x123 and 5,4,0 -> 0x045
        do_op(1'b0, 28'h3215402, 12'h123, 12'h045, 3'd2, 12'h168);
        @(posedge clk); #1;

        // subtract underflow with the consumer stalled for five cycles
        bus1.res_ready = 1'b0;
        do_op(1'b1, 28'h0010026, 12'h001, 12'h002, 3'd6, 12'hFFF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_res_valid", bus1.res_valid, 1);
            chk("hold_res", bus1.res, 12'hFFF);
            chk("hold_nib_ready", bus1.nib_ready, 0);
        end
        bus1.res_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_res_valid", bus1.res_valid, 0);

        // AND giving zero
        do_op(1'b1, 28'h0010023, 12'h001, 12'h002, 3'd3, 12'h000);
        @(posedge clk); #1;

        // reset after the second B nibble
        for (int i = 0; i < 5; i++) send_nib(1'b1, 4'(28'h1230452 >> (24 - 4*i)));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_reset_vals();
        chk("mid_rst_ready", bus1.nib_ready, 1);
        do_op(1'b1, 28'h007008A, 12'h007, 12'h008, 3'd2, 12'h00F);
        @(posedge clk); #1;

        // stray nibbles while holding a result must be ignored
        bus1.res_ready = 1'b0;
        do_op(1'b1, 28'h4560012, 12'h456, 12'h001, 3'd2, 12'h457);
        bus1.nib = 4'hF;
        bus1.nib_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stray_a", bus1.a, 12'h456);
            chk("stray_b", bus1.b, 12'h001);
            chk("stray_fun", bus1.fun, 2);
            chk("stray_ready", bus1.nib_ready, 0);
        end
        bus1.nib_valid = 1'b0;
        bus1.res_ready = 1'b1;
        @(posedge clk); #1;
        do_op(1'b1, 28'h2000012, 12'h200, 12'h001, 3'd2, 12'h201);

        k = 0;
        while ((q1.size() + q0.size()) != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("sb_drain", int'(q1.size() + q0.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
